// File: rtl/toggle_period_checker.sv
// toggle_period_checker: measures the clocks between transitions of a
// synchronous toggling line and checks each one against an expected
// half-period with a +/- tolerance.
// Lock is declared after a run of good measurements.
// A line that stops toggling is reported as a stall.
module toggle_period_checker #(
   parameter int COUNT_LIMIT = 10,
   parameter int TOLERANCE   = 0,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 2 * COUNT_LIMIT,
   localparam int HP_W       = $clog2(TIMEOUT + 1)
) (
   input  logic            i_Clk,
   input  logic            i_Reset,
   input  logic            i_Enable,
   input  logic            i_Toggle,
   output logic [HP_W-1:0] o_Half_Period,
   output logic            o_Valid,
   output logic            o_Match,
   output logic            o_Locked,
   output logic            o_Timeout
);

   // The counter must be able to hold TIMEOUT+1 without wrapping.
   // That value marks a stall.
   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam int RUN_W = $clog2(LOCK_COUNT + 1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(LOCK_COUNT);
   localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

   logic [0:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [HP_W-1:0]  half_q, half_d;
   logic             toggle_q;
   logic             match_q, match_d;
   logic             locked_q, locked_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   logic             transition;
   logic             in_tol;
   logic [31:0]      period_ext;
   logic [RUN_W-1:0] run_inc;

   assign transition = i_Toggle ^ toggle_q;

   // Tolerance window check, phrased so that the lower bound cannot underflow.
   assign period_ext = 32'(cnt_q);
   assign in_tol     = ((period_ext + 32'(TOLERANCE)) >= 32'(COUNT_LIMIT)) &&
                       (period_ext <= 32'(COUNT_LIMIT + TOLERANCE));

   // The match run saturates at LOCK_COUNT, so lock holds while matches continue.
   assign run_inc = (run_q == RUN_FULL) ? RUN_FULL : (run_q + RUN_ONE);

   // Next-state logic.
   // Disabling forces IDLE, which takes priority over measurement.
   // In MEASURE, a stall takes priority over a late transition.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      half_d    = half_q;
      match_d   = match_q;
      locked_d  = locked_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      if (!i_Enable) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         run_d    = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (transition) begin
                  state_d = ST_MEASURE;
                  cnt_d   = CNT_ONE;
               end
            end
            ST_MEASURE: begin
               if (cnt_q == CNT_STALL) begin
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  run_d     = '0;
                  cnt_d     = '0;
                  state_d   = ST_IDLE;
               end else if (transition) begin
                  valid_d = 1'b1;
                  half_d  = HP_W'(cnt_q);
                  match_d = in_tol;
                  cnt_d   = CNT_ONE;
                  if (in_tol) begin
                     run_d    = run_inc;
                     locked_d = (run_inc == RUN_FULL);
                  end else begin
                     run_d    = '0;
                     locked_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               run_d    = '0;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   // The registered previous value of the line is updated every clock,
   // so that edges are tracked even while measurement is disabled.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         run_q     <= '0;
         half_q    <= '0;
         toggle_q  <= 1'b0;
         match_q   <= 1'b0;
         locked_q  <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         half_q    <= half_d;
         toggle_q  <= i_Toggle;
         match_q   <= match_d;
         locked_q  <= locked_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_Half_Period = half_q;
   assign o_Valid       = valid_q;
   assign o_Match       = match_q;
   assign o_Locked      = locked_q;
   assign o_Timeout     = timeout_q;

endmodule

// File: tb/tb_toggle_period_checker.sv
// tb_toggle_period_checker: directed bench for toggle_period_checker.
// Three instances share one set of inputs:
//   A: default parameters
//   B: TOLERANCE=1
//   C: LOCK_COUNT=1
module tb_toggle_period_checker;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       toggle;

   logic [4:0] halfA, halfB, halfC;
   logic       validA, validB, validC;
   logic       matchA, matchB, matchC;
   logic       lockedA, lockedB, lockedC;
   logic       timeoutA, timeoutB, timeoutC;

   int         passCount  = 0;
   int         checkCount = 0;
   int         failCount  = 0;
   logic       pulseSeen;

   toggle_period_checker dutA (
      .i_Clk(clk), .i_Reset(rst), .i_Enable(enable), .i_Toggle(toggle),
      .o_Half_Period(halfA), .o_Valid(validA), .o_Match(matchA),
      .o_Locked(lockedA), .o_Timeout(timeoutA)
   );

   toggle_period_checker #(.TOLERANCE(1)) dutB (
      .i_Clk(clk), .i_Reset(rst), .i_Enable(enable), .i_Toggle(toggle),
      .o_Half_Period(halfB), .o_Valid(validB), .o_Match(matchB),
      .o_Locked(lockedB), .o_Timeout(timeoutB)
   );

   toggle_period_checker #(.LOCK_COUNT(1)) dutC (
      .i_Clk(clk), .i_Reset(rst), .i_Enable(enable), .i_Toggle(toggle),
      .o_Half_Period(halfC), .o_Valid(validC), .o_Match(matchC),
      .o_Locked(lockedC), .o_Timeout(timeoutC)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance by whole clocks.
   // Afterwards, sit 1 ns past the rising edge.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Produce a transition that is detected exactly n clocks after the previous detection.
   task automatic measure(input int n);
      applyStimulus(n - 1);
      toggle = ~toggle;
      applyStimulus(1);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic resetAll();
      rst    = 1'b1;
      toggle = 1'b0;
      applyStimulus(2);
      rst    = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b0;
      toggle = 1'b0;
      applyStimulus(2);
      checkOutput("reset half", 32'(halfA), 32'd0);
      checkOutput("reset valid", 32'(validA), 32'd0);
      checkOutput("reset match", 32'(matchA), 32'd0);
      checkOutput("reset locked", 32'(lockedA), 32'd0);
      checkOutput("reset timeout", 32'(timeoutA), 32'd0);
      rst    = 1'b0;
      enable = 1'b1;

      $display("[TB] nominal lock");
      toggle = ~toggle;
      applyStimulus(1);
      checkOutput("arm no valid", 32'(validA), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         measure(10);
         checkOutput("nom valid", 32'(validA), 32'd1);
         checkOutput("nom half", 32'(halfA), 32'd10);
         checkOutput("nom match", 32'(matchA), 32'd1);
         checkOutput("nom locked", 32'(lockedA), (k >= 4) ? 32'd1 : 32'd0);
         checkOutput("lock1 locked", 32'(lockedC), 32'd1);
      end
      applyStimulus(1);
      checkOutput("valid one cycle", 32'(validA), 32'd0);

      $display("[TB] timeout");
      applyStimulus(19);
      checkOutput("no early timeout", 32'(timeoutA), 32'd0);
      checkOutput("locked before stall", 32'(lockedA), 32'd1);
      applyStimulus(1);
      checkOutput("timeout pulse", 32'(timeoutA), 32'd1);
      checkOutput("timeout locked", 32'(lockedA), 32'd0);
      checkOutput("timeout half held", 32'(halfA), 32'd10);
      checkOutput("timeout match held", 32'(matchA), 32'd1);
      checkOutput("timeout no valid", 32'(validA), 32'd0);
      checkOutput("timeout C", 32'(timeoutC), 32'd1);
      applyStimulus(1);
      checkOutput("timeout one cycle", 32'(timeoutA), 32'd0);
      toggle = ~toggle;
      applyStimulus(1);
      checkOutput("rearm no valid", 32'(validA), 32'd0);
      measure(20);
      checkOutput("p20 valid", 32'(validA), 32'd1);
      checkOutput("p20 half", 32'(halfA), 32'd20);
      checkOutput("p20 match", 32'(matchA), 32'd0);
      checkOutput("p20 no timeout", 32'(timeoutA), 32'd0);

      $display("[TB] tolerance");
      resetAll();
      toggle = ~toggle;
      applyStimulus(1);
      measure(9);
      checkOutput("tol9 half", 32'(halfB), 32'd9);
      checkOutput("tol9 match", 32'(matchB), 32'd1);
      checkOutput("tol0 p9 match", 32'(matchA), 32'd0);
      checkOutput("lock1 mismatch", 32'(lockedC), 32'd0);
      measure(11);
      checkOutput("tol11 match", 32'(matchB), 32'd1);
      checkOutput("tol11 locked", 32'(lockedB), 32'd0);
      measure(10);
      measure(10);
      checkOutput("tol lock", 32'(lockedB), 32'd1);
      measure(12);
      checkOutput("tol12 half", 32'(halfB), 32'd12);
      checkOutput("tol12 match", 32'(matchB), 32'd0);
      checkOutput("tol12 locked", 32'(lockedB), 32'd0);
      measure(10);
      checkOutput("run cleared match", 32'(matchB), 32'd1);
      checkOutput("run cleared locked", 32'(lockedB), 32'd0);

      $display("[TB] enable drop");
      resetAll();
      toggle = ~toggle;
      applyStimulus(1);
      for (int k = 0; k < 4; k++) measure(10);
      checkOutput("pre-drop locked", 32'(lockedA), 32'd1);
      enable = 1'b0;
      applyStimulus(1);
      checkOutput("drop locked", 32'(lockedA), 32'd0);
      checkOutput("drop half held", 32'(halfA), 32'd10);
      checkOutput("drop match held", 32'(matchA), 32'd1);
      applyStimulus(2);
      toggle = ~toggle;
      applyStimulus(1);
      checkOutput("drop toggle no valid", 32'(validA), 32'd0);
      applyStimulus(1);
      enable = 1'b1;
      toggle = ~toggle;
      applyStimulus(1);
      checkOutput("reenable arm no valid", 32'(validA), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         measure(10);
         checkOutput("relock valid", 32'(validA), 32'd1);
         checkOutput("relock locked", 32'(lockedA), (k == 4) ? 32'd1 : 32'd0);
      end

      $display("[TB] async reset");
      resetAll();
      toggle = ~toggle;
      applyStimulus(1);
      for (int k = 0; k < 3; k++) measure(10);
      applyStimulus(4);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async half", 32'(halfA), 32'd0);
      checkOutput("async match", 32'(matchA), 32'd0);
      checkOutput("async valid", 32'(validA), 32'd0);
      checkOutput("async locked C", 32'(lockedC), 32'd0);
      applyStimulus(2);
      rst = 1'b0;
      pulseSeen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         applyStimulus(1);
         if (validA || timeoutA) pulseSeen = 1'b1;
      end
      checkOutput("no pulse after reset", 32'(pulseSeen), 32'd0);
      toggle = ~toggle;
      applyStimulus(1);
      checkOutput("post-reset arm", 32'(validA), 32'd0);
      measure(10);
      checkOutput("post-reset valid", 32'(validA), 32'd1);
      checkOutput("post-reset half", 32'(halfA), 32'd10);
      checkOutput("post-reset lock1", 32'(lockedC), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
